// File: rtl/out_port_arbiter.sv
// Output-port scheduler: strict-priority, round-robin tie-break grant of one input,
// forwarding its word stream. Optional watchdog enabled by defining ARB_WATCHDOG_EN.
module out_port_arbiter #(
  parameter int unsigned PORT_NUM   = 16,
  parameter int unsigned WDOG_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORT_NUM-1:0]   req,
  input  logic [PORT_NUM*3-1:0] req_prior,
  input  logic [PORT_NUM*9-1:0] req_length,
  input  logic [PORT_NUM-1:0]   in_vld,
  input  logic [PORT_NUM*16-1:0] in_data,
  output logic [PORT_NUM-1:0]   grant,
  output logic [PORT_NUM-1:0]   xfer_stop,
  output logic                  out_vld,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [15:0]           out_data,
  output logic [2:0]            out_prior,
  output logic                  busy,
  output logic                  err_dup,
  output logic                  timeout
);

  localparam int unsigned IdxW = $clog2(PORT_NUM);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e              state_q;
  logic [PORT_NUM-1:0] grant_q;
  logic [IdxW-1:0]     gidx_q;
  logic [IdxW-1:0]     rr_ptr_q;
  logic                out_vld_q, out_sop_q, out_eop_q, busy_q, err_dup_q;
  logic [15:0]         out_data_q;
  logic [2:0]          out_prior_q;
  logic [8:0]          len_q, cnt_q;

  logic [PORT_NUM-1:0] pending_q;
  logic [2:0]          pend_prior_q [PORT_NUM];
  logic [8:0]          pend_len_q   [PORT_NUM];

  logic                sel_found;
  logic [IdxW-1:0]     sel_idx, cand;
  logic [2:0]          sel_prior;
  logic [8:0]          sel_len;
  logic                in_vld_g, last_word, wdog_fire, rel_now, select;
  logic [15:0]         data_g;
  logic [PORT_NUM-1:0] dup_vec, accept;

  // Scan from rr_ptr so that a strict '>' keeps the first tied index in rotation order.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_prior = '0;
    sel_len   = '0;
    cand      = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      cand = IdxW'((int'(rr_ptr_q) + k) % int'(PORT_NUM));
      if (pending_q[cand] && (!sel_found || pend_prior_q[cand] > sel_prior)) begin
        sel_found = 1'b1;
        sel_idx   = cand;
        sel_prior = pend_prior_q[cand];
        sel_len   = pend_len_q[cand];
      end
    end
  end

  always_comb begin
    data_g   = '0;
    in_vld_g = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (gidx_q == IdxW'(i)) begin
        data_g   = in_data[16*i +: 16];
        in_vld_g = in_vld[i];
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  logic [6:0] wdog_q;
  logic       timeout_q;
  assign wdog_fire = (state_q == StXfer) && !in_vld_g && (wdog_q == 7'(WDOG_LIMIT - 1));
  assign timeout   = timeout_q;
`else
  assign wdog_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign last_word = (state_q == StXfer) && in_vld_g && ((cnt_q + 9'd1) == len_q);
  assign rel_now   = last_word || wdog_fire;
  assign select    = (state_q == StIdle) && sel_found;
  // A grant being released this edge does not make a fresh req a duplicate.
  assign dup_vec   = req & (pending_q | (grant_q & ~{PORT_NUM{rel_now}}));
  assign accept    = req & ~dup_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      err_dup_q <= 1'b0;
      for (int i = 0; i < PORT_NUM; i++) begin
        pend_prior_q[i] <= '0;
        pend_len_q[i]   <= '0;
      end
    end else begin
      if (|dup_vec) err_dup_q <= 1'b1;
      for (int i = 0; i < PORT_NUM; i++) begin
        if (accept[i]) begin
          pending_q[i]    <= 1'b1;
          pend_prior_q[i] <= req_prior[3*i +: 3];
          pend_len_q[i]   <= req_length[9*i +: 9];
        end else if (select && sel_idx == IdxW'(i)) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      out_vld_q   <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
      out_prior_q <= '0;
      busy_q      <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
`ifdef ARB_WATCHDOG_EN
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      out_vld_q <= 1'b0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            grant_q          <= '0;
            grant_q[sel_idx] <= 1'b1;
            gidx_q           <= sel_idx;
            out_prior_q      <= sel_prior;
            len_q            <= (sel_len == 9'd0) ? 9'd1 : sel_len;
            cnt_q            <= '0;
            busy_q           <= 1'b1;
            rr_ptr_q         <= (sel_idx == IdxW'(PORT_NUM - 1)) ? '0 : sel_idx + 1'b1;
            state_q          <= StXfer;
`ifdef ARB_WATCHDOG_EN
            wdog_q           <= '0;
`endif
          end
        end
        StXfer: begin
          if (in_vld_g) begin
            out_vld_q  <= 1'b1;
            out_data_q <= data_g;
            out_sop_q  <= (cnt_q == 9'd0);
            cnt_q      <= cnt_q + 9'd1;
`ifdef ARB_WATCHDOG_EN
            wdog_q     <= '0;
`endif
            if (last_word) begin
              out_eop_q <= 1'b1;
              grant_q   <= '0;
              busy_q    <= 1'b0;
              state_q   <= StIdle;
            end
          end
`ifdef ARB_WATCHDOG_EN
          else if (wdog_fire) begin
            out_eop_q <= 1'b1;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            wdog_q <= wdog_q + 7'd1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant     = grant_q;
  assign xfer_stop = ~grant_q;
  assign out_vld   = out_vld_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_data  = out_data_q;
  assign out_prior = out_prior_q;
  assign busy      = busy_q;
  assign err_dup   = err_dup_q;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed-vector bench for out_port_arbiter; watchdog checks build with ARB_WATCHDOG_EN.
module tb_out_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  req, in_vld;
  logic [47:0]  req_prior;
  logic [143:0] req_length;
  logic [255:0] in_data;
  logic [15:0]  grant, xfer_stop, out_data;
  logic         out_vld, out_sop, out_eop, busy, err_dup, timeout;
  logic [2:0]   out_prior;

  int checks = 0;
  int errors = 0;

  out_port_arbiter #(.PORT_NUM(16), .WDOG_LIMIT(64)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_prior  (req_prior),
    .req_length (req_length),
    .in_vld     (in_vld),
    .in_data    (in_data),
    .grant      (grant),
    .xfer_stop  (xfer_stop),
    .out_vld    (out_vld),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_data   (out_data),
    .out_prior  (out_prior),
    .busy       (busy),
    .err_dup    (err_dup),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] p, input logic [8:0] l);
    req[i] = 1'b1;
    req_prior[3*i +: 3]  = p;
    req_length[9*i +: 9] = l;
  endtask

  task automatic set_word(input int i, input logic [15:0] d);
    in_vld[i] = 1'b1;
    in_data[16*i +: 16] = d;
  endtask

  // req and in_vld are one-cycle pulses, dropped right after each edge.
  task automatic tick();
    @(posedge clk);
    #1;
    req    = '0;
    in_vld = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " grant"},     32'(grant),     32'h0);
    check({tag, " xfer_stop"}, 32'(xfer_stop), 32'hFFFF);
    check({tag, " vld/sop/eop"}, {29'd0, out_vld, out_sop, out_eop}, 32'h0);
    check({tag, " out_data"},  32'(out_data),  32'h0);
    check({tag, " out_prior"}, 32'(out_prior), 32'h0);
    check({tag, " busy"},      32'(busy),      32'h0);
    check({tag, " err_dup"},   32'(err_dup),   32'h0);
    check({tag, " timeout"},   32'(timeout),   32'h0);
  endtask

  int order [3] = '{2, 5, 12};

  initial begin
    rst_n = 1'b0;
    req = '0; in_vld = '0; req_prior = '0; req_length = '0; in_data = '0;
    #12;
    rst_n = 1'b1;
    #2;
    check_reset_outputs("reset");

    // Single 4-word packet on input 3; a req on its eop edge is accepted.
    set_req(3, 3'd2, 9'd4);
    tick();
    check("t1 grant after N", 32'(grant), 32'h0);
    tick();
    check("t1 grant N+2", 32'(grant), 32'h0008);
    check("t1 xfer_stop", 32'(xfer_stop), 32'hFFF7);
    check("t1 busy", 32'(busy), 32'h1);
    check("t1 out_prior", 32'(out_prior), 32'd2);
    for (int w = 0; w < 4; w++) begin
      set_word(3, 16'hA000 + 16'(w));
      if (w == 3) set_req(3, 3'd1, 9'd1);
      tick();
      check("t1 vld", 32'(out_vld), 32'h1);
      check("t1 data", 32'(out_data), 32'hA000 + 32'(w));
      check("t1 sop", 32'(out_sop), 32'(w == 0));
      check("t1 eop", 32'(out_eop), 32'(w == 3));
    end
    check("t1 grant released", 32'(grant), 32'h0);
    check("t1 xfer_stop idle", 32'(xfer_stop), 32'hFFFF);
    check("t1 busy idle", 32'(busy), 32'h0);
    check("t1 eop-edge req no err", 32'(err_dup), 32'h0);
    tick();
    check("t1 regrant after bubble", 32'(grant), 32'h0008);
    check("t1 regrant prior", 32'(out_prior), 32'd1);
    set_word(3, 16'hBEEF);
    tick();
    check("t1 1-word sop/eop", {30'd0, out_sop, out_eop}, 32'h3);
    tick();
    check("t1 vld drops", 32'(out_vld), 32'h0);

    // Strict priority: 9 (prior 6) beats 1 (prior 5); non-granted in_vld ignored.
    set_req(1, 3'd5, 9'd1);
    set_req(9, 3'd6, 9'd1);
    tick();
    tick();
    check("t2 grant 9", 32'(grant), 32'h0200);
    check("t2 prior 6", 32'(out_prior), 32'd6);
    set_word(1, 16'h1111);
    tick();
    check("t2 foreign vld ignored", 32'(out_vld), 32'h0);
    set_word(9, 16'h9999);
    tick();
    check("t2 data 9", 32'(out_data), 32'h9999);
    check("t2 eop 9", 32'(out_eop), 32'h1);
    check("t2 grant cleared", 32'(grant), 32'h0);
    tick();
    check("t2 grant 1", 32'(grant), 32'h0002);
    set_word(1, 16'h1111);
    tick();
    check("t2 eop 1", 32'(out_eop), 32'h1);

    // Equal-priority round robin, three rounds; rr_ptr starts at 2.
    for (int r = 0; r < 3; r++) begin
      set_req(2, 3'd3, 9'd1);
      set_req(5, 3'd3, 9'd1);
      set_req(12, 3'd3, 9'd1);
      tick();
      for (int j = 0; j < 3; j++) begin
        tick();
        check($sformatf("t3 r%0d grant", r), 32'(grant), 32'h1 << order[j]);
        set_word(order[j], 16'h3000 + 16'(order[j]));
        tick();
        check($sformatf("t3 r%0d eop", r), 32'(out_eop), 32'h1);
      end
    end
    // rr_ptr is now 13: input 14 precedes input 2 after the wrap.
    set_req(2, 3'd3, 9'd1);
    set_req(14, 3'd3, 9'd1);
    tick();
    tick();
    check("t3 wrap first 14", 32'(grant), 32'h4000);
    set_word(14, 16'hE0E0);
    tick();
    tick();
    check("t3 wrap then 2", 32'(grant), 32'h0004);
    set_word(2, 16'h0202);
    tick();

    // Length 0 is one word; req on the eop edge of the same input is accepted.
    set_req(6, 3'd0, 9'd0);
    tick();
    tick();
    check("t5 grant 6", 32'(grant), 32'h0040);
    set_word(6, 16'h0600);
    set_req(6, 3'd4, 9'd0);
    tick();
    check("t5 len0 vld/sop/eop", {29'd0, out_vld, out_sop, out_eop}, 32'h7);
    check("t5 no err", 32'(err_dup), 32'h0);
    tick();
    check("t5 regrant 6", 32'(grant), 32'h0040);
    check("t5 regrant prior", 32'(out_prior), 32'd4);
    set_word(6, 16'h0601);
    tick();
    check("t5 eop", 32'(out_eop), 32'h1);

    // Duplicate req while granted: flagged and dropped, packet unaffected.
    set_req(4, 3'd1, 9'd2);
    tick();
    tick();
    check("t4 grant 4", 32'(grant), 32'h0010);
    set_word(4, 16'h4441);
    tick();
    check("t4 sop", 32'(out_sop), 32'h1);
    set_req(4, 3'd7, 9'd9);
    tick();
    check("t4 err_dup", 32'(err_dup), 32'h1);
    check("t4 grant held", 32'(grant), 32'h0010);
    check("t4 prior held", 32'(out_prior), 32'd1);
    set_word(4, 16'h4442);
    tick();
    check("t4 eop data", {15'd0, out_eop, out_data}, {15'd0, 1'b1, 16'h4442});
    tick();
    tick();
    check("t4 dup not pending", 32'(grant), 32'h0);
    check("t4 err_dup sticky", 32'(err_dup), 32'h1);

`ifdef ARB_WATCHDOG_EN
    begin
      int n;
      set_req(7, 3'd2, 9'd3);
      tick();
      tick();
      check("wd grant 7", 32'(grant), 32'h0080);
      set_word(7, 16'h7777);
      tick();
      n = 0;
      while (n < 100 && !out_eop) begin
        tick();
        n++;
      end
      check("wd stall cycles", 32'(n), 32'd64);
      check("wd vld low", 32'(out_vld), 32'h0);
      check("wd timeout", 32'(timeout), 32'h1);
      check("wd grant released", 32'(grant), 32'h0);
    end
`endif

    // Async reset mid-packet: outputs clear immediately, pending work is lost.
    set_req(8, 3'd3, 9'd5);
    tick();
    tick();
    check("rst grant 8", 32'(grant), 32'h0100);
    set_word(8, 16'h8881);
    tick();
    set_word(8, 16'h8882);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async rst");
    #2;
    rst_n = 1'b1;
    tick();
    check("post rst grant", 32'(grant), 32'h0);
    check("post rst vld", 32'(out_vld), 32'h0);
    tick();
    check("post rst idle", 32'(grant), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_port_arbiter.md
# out_port_arbiter

Per-output-port scheduler for the switch fabric. It sits downstream of the 16 input `port` blocks and collects their one-cycle `new_packet` announcements (prior, length) addressed to this output. It grants one input at a time by strict priority with round-robin tie-break. It gates all other inputs with `xfer_stop`, forwards the granted input's word stream to the output, and releases the grant after `length` words.

## Interface
- PORT_NUM, 16, number of input ports (index width 4)
- WDOG_LIMIT, 64, idle-cycle limit for watchdog (only with ARB_WATCHDOG_EN)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous active-low
- req  in  PORT_NUM  one-cycle packet announcement per input (already filtered on dest_port == this output)
- req_prior  in  PORT_NUM*3  priority of input i at bits [3i+2:3i]; 7 highest
- req_length  in  PORT_NUM*9  payload word count of input i at [9i+8:9i]
- in_vld  in  PORT_NUM  data valid per input
- in_data  in  PORT_NUM*16  data word of input i at [16i+15:16i]
- grant  out  PORT_NUM  one-hot current grant, 0 when idle
- xfer_stop  out  PORT_NUM  equals ~grant
- out_vld / out_sop / out_eop  out  1 each  output word strobes
- out_data  out  16  forwarded word
- out_prior  out  3  priority of packet in flight
- busy  out  1  high in XFER
- err_dup  out  1  sticky: req on an input already pending or granted
- timeout  out  1  sticky watchdog flag (held 0 without macro)

## Operation
- Per-input pending bit plus latched prior[2:0] and length[8:0], captured on req.
- req while pending[i] or grant[i] is set: dropped, err_dup set, stored attributes unchanged.
- FSM IDLE -> XFER -> IDLE.
- IDLE, any pending: select highest prior. Ties go to the first pending index at or after rr_ptr, wrapping 15->0.
- On selection: register grant, out_prior, length; clear pending; rr_ptr <= winner+1 (mod 16); go to XFER.
- XFER: each in_vld[g] cycle forwards in_data[g] to out_data with out_vld.
- First forwarded word asserts out_sop.
- 9-bit word counter increments per word. The word where count reaches length asserts out_eop, clears grant and returns to IDLE.
- length 0 is treated as 1.
- in_vld from non-granted inputs is ignored.
- pending and err_dup update in every state.

## Timing
- Reset values: grant=0, xfer_stop=all ones, out_vld/sop/eop=0, out_data=0, out_prior=0, busy=0, err_dup=0, timeout=0, rr_ptr=0, pending=0, state IDLE.
- req at edge N: pending visible N+1; grant/busy asserted N+2 if idle; xfer_stop[g] low from N+2.
- Data latency: in_vld[g] at edge M gives out_vld at M+1.
- out_sop and out_eop coincide on a 1-word packet.
- grant clears on the edge that registers out_eop. The next grant is issued at the earliest 1 cycle later (one idle bubble).
- A req arriving on the eop edge for the just-released input is accepted, not an error.
- Async reset mid-packet: all outputs return to reset values immediately. The packet is truncated with no out_eop and pending requests are lost.

## Configuration
- ARB_WATCHDOG_EN defined: 7-bit idle counter counts XFER cycles without in_vld[g] and resets on each word. On reaching WDOG_LIMIT: force out_eop with out_vld=0, release grant, set timeout, return to IDLE.
- Undefined: no counter; XFER waits indefinitely; timeout tied 0.

## Test plan
- req[3] prior 2 length 4, then 4 consecutive words -> grant=0x0008 at N+2; out_sop on word 1, out_eop on word 4; grant=0 after; xfer_stop=0xFFFF.
- Same-cycle req[1] prior 5 and req[9] prior 6 -> input 9 served first, input 1 granted one cycle after 9's eop.
- req[2],[5],[12] all prior 3, repeated for three rounds -> grant order 2,5,12 per round, round-robin rotating from rr_ptr.
- Second req[4] while 4 is granted -> err_dup=1; the in-flight packet completes unchanged.
- Length 0 packet -> single word with out_sop=out_eop=1.
- Macro on: grant input 7, stall 64 cycles -> out_eop with out_vld=0, timeout=1, grant=0; mid-packet rst_n low -> all outputs at reset values in the same cycle.
